// File: rtl/mul_share_arbiter.sv
// Round-robin sharing of one start/done sequential multiplier among N_REQ requesters,
// with a watchdog that turns a missing done into an error response.
module mul_share_arbiter #(
  parameter int N_REQ   = 4,
  parameter int W       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [N_REQ*W-1:0]   a_in,
  input  logic [N_REQ*W-1:0]   b_in,
  output logic [N_REQ-1:0]     gnt,
  output logic                 busy,
  output logic                 mul_start,
  output logic [W-1:0]         mul_a,
  output logic [W-1:0]         mul_b,
  input  logic                 mul_done,
  input  logic [2*W-1:0]       mul_result,
  output logic [N_REQ-1:0]     resp_valid,
  output logic [2*W-1:0]       resp_data,
  output logic                 resp_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  state_t              state_r;
  logic [PW-1:0]       ptr_r;
  logic [7:0]          wd_r;
  logic [N_REQ-1:0]    gnt_r;
  logic                busy_r;
  logic                mul_start_r;
  logic [W-1:0]        mul_a_r;
  logic [W-1:0]        mul_b_r;
  logic [N_REQ-1:0]    resp_valid_r;
  logic [2*W-1:0]      resp_data_r;
  logic                resp_err_r;

  logic                win_found_s;
  logic [PW-1:0]       win_idx_s;
  logic [PW-1:0]       scan_idx_s;
  logic [N_REQ-1:0]    win_onehot_s;
  logic                wd_expire_s;

  // Round-robin winner search, starting one past the last granted index
  always_comb begin
    win_found_s  = 1'b0;
    win_idx_s    = '0;
    scan_idx_s   = ptr_r;
    win_onehot_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (scan_idx_s == PW'(N_REQ - 1)) begin
        scan_idx_s = '0;
      end else begin
        scan_idx_s = scan_idx_s + 1'b1;
      end
      if (!win_found_s && req[scan_idx_s]) begin
        win_found_s = 1'b1;
        win_idx_s   = scan_idx_s;
      end else begin
        win_found_s = win_found_s;
      end
    end
    win_onehot_s[win_idx_s] = 1'b1;
  end

  // Watchdog fires on the TIMEOUT-th WAIT cycle (counter holds cycles already spent)
  assign wd_expire_s = (({1'b0, wd_r} + 9'd1) == 9'(TIMEOUT));

  // Arbitration FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      ptr_r        <= PW'(N_REQ - 1);
      wd_r         <= 8'd0;
      gnt_r        <= '0;
      busy_r       <= 1'b0;
      mul_start_r  <= 1'b0;
      mul_a_r      <= '0;
      mul_b_r      <= '0;
      resp_valid_r <= '0;
      resp_data_r  <= '0;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (win_found_s) begin
            gnt_r       <= win_onehot_s;
            mul_a_r     <= a_in[int'(win_idx_s)*W +: W];
            mul_b_r     <= b_in[int'(win_idx_s)*W +: W];
            ptr_r       <= win_idx_s;
            busy_r      <= 1'b1;
            mul_start_r <= 1'b1;
            state_r     <= ST_ISSUE;
          end else begin
            state_r     <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          wd_r    <= 8'd0;
          state_r <= ST_WAIT;
        end
        ST_WAIT: begin
          wd_r <= wd_r + 8'd1;
          if (mul_done) begin
            resp_data_r  <= mul_result;
            resp_err_r   <= 1'b0;
            resp_valid_r <= gnt_r;
            mul_start_r  <= 1'b0;
            state_r      <= ST_RESP;
          end else if (wd_expire_s) begin
            resp_data_r  <= '0;
            resp_err_r   <= 1'b1;
            resp_valid_r <= gnt_r;
            mul_start_r  <= 1'b0;
            state_r      <= ST_RESP;
          end else begin
            state_r      <= ST_WAIT;
          end
        end
        ST_RESP: begin
          resp_valid_r <= '0;
          resp_err_r   <= 1'b0;
          gnt_r        <= '0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
        default: begin
          mul_start_r  <= 1'b0;
          resp_valid_r <= '0;
          gnt_r        <= '0;
          busy_r       <= 1'b0;
          state_r      <= ST_IDLE;
        end
      endcase
    end
  end

  assign gnt        = gnt_r;
  assign busy       = busy_r;
  assign mul_start  = mul_start_r;
  assign mul_a      = mul_a_r;
  assign mul_b      = mul_b_r;
  assign resp_valid = resp_valid_r;
  assign resp_data  = resp_data_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed bench for mul_share_arbiter with a behavioural start/done multiplier
// whose done latency can be set or suppressed.
module tb_mul_share_arbiter;

  localparam int N_REQ = 4;
  localparam int W     = 8;

  logic                 clk;
  logic                 rst;
  logic [N_REQ-1:0]     req;
  logic [N_REQ*W-1:0]   a_in;
  logic [N_REQ*W-1:0]   b_in;
  logic [N_REQ-1:0]     gnt;
  logic                 busy;
  logic                 mul_start;
  logic [W-1:0]         mul_a;
  logic [W-1:0]         mul_b;
  logic                 mul_done;
  logic [2*W-1:0]       mul_result;
  logic [N_REQ-1:0]     resp_valid;
  logic [2*W-1:0]       resp_data;
  logic                 resp_err;

  int checks = 0;
  int errors = 0;
  int done_lat = 5;
  bit done_en = 1'b1;
  int mcnt = 0;

  mul_share_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_done(mul_done), .mul_result(mul_result),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_err(resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier model: done rises done_lat cycles after start is first seen high
  always @(posedge clk) begin
    if (!mul_start) begin
      mcnt       <= 0;
      mul_done   <= 1'b0;
      mul_result <= '0;
    end else begin
      mcnt       <= mcnt + 1;
      mul_done   <= done_en && ((mcnt + 1) >= done_lat);
      mul_result <= {8'd0, mul_a} * {8'd0, mul_b};
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  initial begin
    rst  = 1'b0;
    req  = '0;
    a_in = '0;
    b_in = '0;
    mul_done = 1'b0;
    mul_result = '0;
    step(2);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", 32'(resp_data), 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    rst = 1'b1;
    step(1);

    // Single operation: 13 x 11, done 5 cycles after start
    done_lat = 5;
    set_op(0, 8'd13, 8'd11);
    req = 4'b0001;
    step(1);
    chk("t1_gnt", 32'(gnt), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_start", 32'(mul_start), 32'd1);
    chk("t1_mul_a", 32'(mul_a), 32'd13);
    chk("t1_mul_b", 32'(mul_b), 32'd11);
    step(5);
    chk("t1_c6_valid", 32'(resp_valid), 32'd0);
    chk("t1_c6_start", 32'(mul_start), 32'd1);
    step(1);
    chk("t1_c7_valid", 32'(resp_valid), 32'd1);
    chk("t1_c7_data", 32'(resp_data), 32'd143);
    chk("t1_c7_err", 32'(resp_err), 32'd0);
    chk("t1_c7_start", 32'(mul_start), 32'd0);
    req = 4'b0000;
    step(1);
    chk("t1_c8_busy", 32'(busy), 32'd0);
    chk("t1_c8_valid", 32'(resp_valid), 32'd0);
    chk("t1_c8_gnt", 32'(gnt), 32'd0);
    chk("t1_c8_data_hold", 32'(resp_data), 32'd143);

    // Round robin from a fresh reset, all four requesting
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    step(1);
    for (int i = 0; i < N_REQ; i++) set_op(i, W'(i + 1), 8'd2);
    done_lat = 3;
    req = 4'b1111;
    step(1);
    for (int n = 0; n < 5; n++) begin
      chk("rr_gnt", 32'(gnt), 32'(4'b0001 << (n % 4)));
      chk("rr_onehot", 32'($countones(gnt)), 32'd1);
      step(4);
      chk("rr_valid", 32'(resp_valid), 32'(4'b0001 << (n % 4)));
      chk("rr_data", 32'(resp_data), 32'(((n % 4) + 1) * 2));
      if (n == 4) req = 4'b0000;
      step(2);
    end
    chk("rr_idle_gnt", 32'(gnt), 32'd0);

    // Timeout: done never arrives
    done_en = 1'b0;
    set_op(1, 8'd3, 8'd4);
    req = 4'b0010;
    step(1);
    chk("to_gnt", 32'(gnt), 32'b0010);
    step(15);
    chk("to_c16_valid", 32'(resp_valid), 32'd0);
    chk("to_c16_start", 32'(mul_start), 32'd1);
    step(1);
    chk("to_c17_valid", 32'(resp_valid), 32'b0010);
    chk("to_c17_err", 32'(resp_err), 32'd1);
    chk("to_c17_data", 32'(resp_data), 32'd0);
    chk("to_c17_start", 32'(mul_start), 32'd0);
    req = 4'b0000;
    done_en = 1'b1;
    step(1);
    chk("to_c18_busy", 32'(busy), 32'd0);

    // Requester 2 drops req while waiting; response still delivered
    done_lat = 5;
    set_op(2, 8'd20, 8'd5);
    req = 4'b0100;
    step(1);
    chk("drop_gnt", 32'(gnt), 32'b0100);
    step(2);
    req = 4'b0000;
    step(4);
    chk("drop_valid", 32'(resp_valid), 32'b0100);
    chk("drop_data", 32'(resp_data), 32'd100);
    step(1);
    chk("drop_valid_once", 32'(resp_valid), 32'd0);
    chk("drop_busy", 32'(busy), 32'd0);
    step(2);
    chk("drop_no_regrant", 32'(gnt), 32'd0);

    // Reset in the middle of WAIT
    set_op(3, 8'd7, 8'd9);
    req = 4'b1000;
    step(1);
    chk("mr_gnt", 32'(gnt), 32'b1000);
    step(2);
    rst = 1'b0;
    #1;
    chk("mr_gnt0", 32'(gnt), 32'd0);
    chk("mr_busy0", 32'(busy), 32'd0);
    chk("mr_start0", 32'(mul_start), 32'd0);
    chk("mr_mul_a0", 32'(mul_a), 32'd0);
    chk("mr_mul_b0", 32'(mul_b), 32'd0);
    chk("mr_valid0", 32'(resp_valid), 32'd0);
    chk("mr_data0", 32'(resp_data), 32'd0);
    chk("mr_err0", 32'(resp_err), 32'd0);
    set_op(1, 8'd6, 8'd7);
    req = 4'b1010;
    step(1);
    chk("mr_hold_gnt", 32'(gnt), 32'd0);
    rst = 1'b1;
    step(1);
    chk("mr_first_gnt", 32'(gnt), 32'b0010);
    chk("mr_first_mul_a", 32'(mul_a), 32'd6);
    step(6);
    chk("mr_valid", 32'(resp_valid), 32'b0010);
    chk("mr_data", 32'(resp_data), 32'd42);
    req = 4'b0000;
    step(2);

    // Operand stability with maximum operands
    set_op(0, 8'd255, 8'd255);
    req = 4'b0001;
    step(1);
    chk("os_mul_a", 32'(mul_a), 32'd255);
    step(2);
    set_op(0, 8'd1, 8'd1);
    step(1);
    chk("os_mul_a_hold", 32'(mul_a), 32'd255);
    chk("os_mul_b_hold", 32'(mul_b), 32'd255);
    step(3);
    chk("os_valid", 32'(resp_valid), 32'd1);
    chk("os_data", 32'(resp_data), 32'd65025);
    req = 4'b0000;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
